sal_bk_timing_chk: RTL and testbench
====================================

Name: sal_bk_timing_chk

Overview:
- Per-bank timing checker: the consuming end of the bank timing parameter interface.
- Takes the bank timing values t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp and the per-bank command stream.
- Tracks open/closed row state plus one countdown per constraint; reports which commands are legal this cycle.
- One instance per bank, under the scheduler, which issues only commands whose *_ok is high.

Parameters:
- TW, 8, width of each timing value and of each internal counter.
- ROW_W, 14, row address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp  in  TW each  timing values in cycles; quasi-static.
- act_i, rd_i, wr_i, pre_i, ref_i  in  1 each  command issued to this bank this cycle.
- ap_i  in  1  auto-precharge qualifier on rd_i/wr_i.
- row_i  in  ROW_W  row address, sampled with act_i.
- act_ok, rd_ok, wr_ok, pre_ok, ref_ok  out  1 each  command legal now.
- row_open  out  1  bank has an open row.
- open_row  out  ROW_W  currently open row.
- err  out  1  one-cycle pulse on an illegal command.

Interface rule (stated as decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at posedge): state CLOSED, all counters 0, open_row=0, err=0. This gives act_ok=ref_ok=1; rd_ok=wr_ok=pre_ok=0.
- States: CLOSED, OPEN, plus AP_PEND (auto-precharge option only).
- Counters: rcd, ras, rp, rfc, rtp, wtp; each down-counts by 1 per cycle and saturates at 0.
- Load value for constraint t is max(t,1)-1. Effect: a dependent command at cycle N+t is legal when the source command was at cycle N; t=0 behaves as t=1.
- ok outputs depend only on registered state, never on same-cycle inputs:
  - act_ok = ref_ok = CLOSED & rp==0 & rfc==0.
  - rd_ok = wr_ok = OPEN & rcd==0.
  - pre_ok = OPEN & ras==0 & rtp==0 & wtp==0.
- Legal command effects:
  - ACT: ->OPEN; load rcd and ras; open_row<=row_i.
  - RD: rtp <= max(rtp, load(t_rtp)). A shorter new value never shortens a pending wait.
  - WR: wtp <= max(wtp, load(t_wtp)).
  - PRE: ->CLOSED; load rp.
  - REF: load rfc.
- row_open = (state!=CLOSED). open_row holds its value after PRE.
- Illegal command (matching *_ok low, or two or more command strobes in the same cycle):
  - Command ignored; state and counters advance as if idle.
  - err=1 in the next cycle only.
- Counters keep decrementing in every state. Loads take priority over decrement in the same cycle.
- rst mid-operation: immediate return to reset values, regardless of counter contents.
- Timing values are sampled only at load time; changing them mid-count does not affect running counters.

Optional Feature:
- Macro: SAL_BK_AUTO_PRE_EN.
- Defined: a legal RD/WR with ap_i=1 does its normal counter update, then moves to AP_PEND.
  - AP_PEND: rd_ok=wr_ok=pre_ok=act_ok=ref_ok=0; row_open=1.
  - When ras==0 & rtp==0 & wtp==0: internal precharge, ->CLOSED, load rp.
  - Any strobe in AP_PEND is illegal (err).
- Not defined: ap_i is ignored; AP_PEND does not exist.

Decomposition:
- Package sal_bk_pkg:
  - TW and ROW_W defaults.
  - State enum {CLOSED, OPEN, AP_PEND}.
  - Function for the load value max(t,1)-1.
  - Function for max-of-two used in rtp/wtp reload.
- Sub-module sal_dn_cnt: loadable saturating TW-bit down-counter with is_zero output; instantiated six times.

Test Plan:
- Reset, then t_rcd=4: ACT at cycle 10 -> rd_ok rises at cycle 14, not before. open_row equals row_i; row_open=1 from cycle 11.
- t_ras=10, t_rtp=3: ACT at 0, RD at 8 -> pre_ok first high at cycle 11 (rtp bound). With RD at 2 -> pre_ok first high at cycle 10 (ras bound).
- t_wtp=9 then t_rtp=2: WR at 5, RD at 6 -> pre_ok not before cycle 14 (longer wtp wait preserved).
- t_rp=5, t_rfc=20: PRE at 0 -> act_ok high at cycle 5. REF at 5 -> act_ok low until cycle 25.
- RD while CLOSED, or ACT+REF in the same cycle -> err=1 for exactly one cycle; state unchanged. With t_rcd=0 -> rd_ok high the cycle after ACT.
- SAL_BK_AUTO_PRE_EN with t_ras=6, t_rp=3: ACT at 0, RD+ap_i at 2 -> ->CLOSED at cycle 6, act_ok at 9; PRE strobe at 4 -> err. Separately, rst asserted during AP_PEND -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/sal_bk_pkg.sv
// Shared types and helpers for the per-bank timing checker.
package sal_bk_pkg;

  localparam int TW_DEF    = 8;
  localparam int ROW_W_DEF = 14;
  localparam int TW_MAX    = 32;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPEN    = 2'd1,
    AP_PEND = 2'd2
  } bk_state_e;

  // Counter load for a constraint of t cycles: max(t,1)-1.
  function automatic logic [TW_MAX-1:0] ld_val(input logic [TW_MAX-1:0] t);
    logic [TW_MAX-1:0] r;
    if (t == {TW_MAX{1'b0}}) r = {TW_MAX{1'b0}};
    else                     r = t - {{(TW_MAX-1){1'b0}}, 1'b1};
    return r;
  endfunction

  function automatic logic [TW_MAX-1:0] max2(input logic [TW_MAX-1:0] a,
                                             input logic [TW_MAX-1:0] b);
    logic [TW_MAX-1:0] r;
    if (a > b) r = a;
    else       r = b;
    return r;
  endfunction

  function automatic logic [TW_MAX-1:0] sat_dec(input logic [TW_MAX-1:0] a);
    logic [TW_MAX-1:0] r;
    if (a == {TW_MAX{1'b0}}) r = {TW_MAX{1'b0}};
    else                     r = a - {{(TW_MAX-1){1'b0}}, 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/sal_bk_timing_chk_dn_cnt.sv
// sal_dn_cnt: loadable down-counter that saturates at zero; load wins over decrement.
module sal_dn_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != {W{1'b0}}) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/sal_bk_timing_chk.sv
// Per-bank command legality checker. Optional auto-precharge (AP_PEND state)
// is built only when SAL_BK_AUTO_PRE_EN is defined.
module sal_bk_timing_chk
  import sal_bk_pkg::*;
#(
  parameter int TW    = TW_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TW-1:0]    t_rcd,
  input  logic [TW-1:0]    t_rp,
  input  logic [TW-1:0]    t_ras,
  input  logic [TW-1:0]    t_rfc,
  input  logic [TW-1:0]    t_rtp,
  input  logic [TW-1:0]    t_wtp,
  input  logic             act_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             pre_i,
  input  logic             ref_i,
  input  logic             ap_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             act_ok,
  output logic             rd_ok,
  output logic             wr_ok,
  output logic             pre_ok,
  output logic             ref_ok,
  output logic             row_open,
  output logic [ROW_W-1:0] open_row,
  output logic             err
);

  bk_state_e        r_state, w_state_nxt;
  logic [ROW_W-1:0] r_open_row;
  logic             r_err;

  logic [TW-1:0] w_rcd_cnt, w_ras_cnt, w_rp_cnt, w_rfc_cnt, w_rtp_cnt, w_wtp_cnt;
  logic          w_rcd_z, w_ras_z, w_rp_z, w_rfc_z, w_rtp_z, w_wtp_z;
  logic [TW-1:0] w_rcd_val, w_ras_val, w_rp_val, w_rfc_val, w_rtp_val, w_wtp_val;

  logic       w_act_ok, w_rd_ok, w_pre_ok;
  logic [2:0] w_n_cmd;
  logic       w_illegal;
  logic       w_act_go, w_rd_go, w_wr_go, w_pre_go, w_ref_go;
  logic       w_ap_req, w_ap_fire, w_rp_load;
  logic       w_unused;

  assign w_n_cmd   = {2'b00, act_i} + {2'b00, rd_i} + {2'b00, wr_i}
                   + {2'b00, pre_i} + {2'b00, ref_i};
  assign w_illegal = (w_n_cmd > 3'd1)
                   | (act_i & ~w_act_ok) | (rd_i  & ~w_rd_ok) | (wr_i & ~w_rd_ok)
                   | (pre_i & ~w_pre_ok) | (ref_i & ~w_act_ok);

  assign w_act_go = act_i & ~w_illegal;
  assign w_rd_go  = rd_i  & ~w_illegal;
  assign w_wr_go  = wr_i  & ~w_illegal;
  assign w_pre_go = pre_i & ~w_illegal;
  assign w_ref_go = ref_i & ~w_illegal;

`ifdef SAL_BK_AUTO_PRE_EN
  assign w_ap_req  = (w_rd_go | w_wr_go) & ap_i;
  assign w_ap_fire = (r_state == AP_PEND) & w_ras_z & w_rtp_z & w_wtp_z;
`else
  assign w_ap_req  = 1'b0;
  assign w_ap_fire = 1'b0;
`endif
  assign w_rp_load = w_pre_go | w_ap_fire;
  assign w_unused  = ^{ap_i, w_rcd_cnt, w_ras_cnt, w_rp_cnt, w_rfc_cnt};

  // rtp/wtp reload compares against the already-decremented count so the
  // pending wait keeps its original end cycle.
  assign w_rcd_val = TW'(ld_val(TW_MAX'(t_rcd)));
  assign w_ras_val = TW'(ld_val(TW_MAX'(t_ras)));
  assign w_rp_val  = TW'(ld_val(TW_MAX'(t_rp)));
  assign w_rfc_val = TW'(ld_val(TW_MAX'(t_rfc)));
  assign w_rtp_val = TW'(max2(sat_dec(TW_MAX'(w_rtp_cnt)), ld_val(TW_MAX'(t_rtp))));
  assign w_wtp_val = TW'(max2(sat_dec(TW_MAX'(w_wtp_cnt)), ld_val(TW_MAX'(t_wtp))));

  sal_dn_cnt #(.W(TW)) u_rcd (.i_clk(clk), .i_rst(rst), .i_load(w_act_go),
                              .i_val(w_rcd_val), .o_cnt(w_rcd_cnt), .o_zero(w_rcd_z));
  sal_dn_cnt #(.W(TW)) u_ras (.i_clk(clk), .i_rst(rst), .i_load(w_act_go),
                              .i_val(w_ras_val), .o_cnt(w_ras_cnt), .o_zero(w_ras_z));
  sal_dn_cnt #(.W(TW)) u_rp  (.i_clk(clk), .i_rst(rst), .i_load(w_rp_load),
                              .i_val(w_rp_val),  .o_cnt(w_rp_cnt),  .o_zero(w_rp_z));
  sal_dn_cnt #(.W(TW)) u_rfc (.i_clk(clk), .i_rst(rst), .i_load(w_ref_go),
                              .i_val(w_rfc_val), .o_cnt(w_rfc_cnt), .o_zero(w_rfc_z));
  sal_dn_cnt #(.W(TW)) u_rtp (.i_clk(clk), .i_rst(rst), .i_load(w_rd_go),
                              .i_val(w_rtp_val), .o_cnt(w_rtp_cnt), .o_zero(w_rtp_z));
  sal_dn_cnt #(.W(TW)) u_wtp (.i_clk(clk), .i_rst(rst), .i_load(w_wr_go),
                              .i_val(w_wtp_val), .o_cnt(w_wtp_cnt), .o_zero(w_wtp_z));

  always_ff @(posedge clk) begin
    if (rst) r_state <= CLOSED;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLOSED: begin
        if (w_act_go) w_state_nxt = OPEN;
        else          w_state_nxt = CLOSED;
      end
      OPEN: begin
        if (w_pre_go)      w_state_nxt = CLOSED;
        else if (w_ap_req) w_state_nxt = AP_PEND;
        else               w_state_nxt = OPEN;
      end
      AP_PEND: begin
        if (w_ap_fire) w_state_nxt = CLOSED;
        else           w_state_nxt = AP_PEND;
      end
      default: w_state_nxt = CLOSED;
    endcase
  end

  always_comb begin
    w_act_ok = 1'b0;
    w_rd_ok  = 1'b0;
    w_pre_ok = 1'b0;
    case (r_state)
      CLOSED: w_act_ok = w_rp_z & w_rfc_z;
      OPEN: begin
        w_rd_ok  = w_rcd_z;
        w_pre_ok = w_ras_z & w_rtp_z & w_wtp_z;
      end
      default: begin
        w_act_ok = 1'b0;
        w_rd_ok  = 1'b0;
        w_pre_ok = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_open_row <= {ROW_W{1'b0}};
      r_err      <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_act_go) r_open_row <= row_i;
      else          r_open_row <= r_open_row;
    end
  end

  assign act_ok   = w_act_ok;
  assign ref_ok   = w_act_ok;
  assign rd_ok    = w_rd_ok;
  assign wr_ok    = w_rd_ok;
  assign pre_ok   = w_pre_ok;
  assign row_open = (r_state != CLOSED);
  assign open_row = r_open_row;
  assign err      = r_err;

endmodule

// File: tb/tb_sal_bk_timing_chk.sv
// Bench for sal_bk_timing_chk: directed table, test-plan sequences and a
// random run against a deadline-based reference model.
module tb_sal_bk_timing_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
  logic        act_i, rd_i, wr_i, pre_i, ref_i, ap_i;
  logic [13:0] row_i;
  logic        act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open, err;
  logic [13:0] open_row;

  always #5 clk = ~clk;

  sal_bk_timing_chk #(.TW(8), .ROW_W(14)) dut (
    .clk(clk), .rst(rst),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc), .t_rtp(t_rtp), .t_wtp(t_wtp),
    .act_i(act_i), .rd_i(rd_i), .wr_i(wr_i), .pre_i(pre_i), .ref_i(ref_i), .ap_i(ap_i),
    .row_i(row_i),
    .act_ok(act_ok), .rd_ok(rd_ok), .wr_ok(wr_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
    .row_open(row_open), .open_row(open_row), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int base = 0;

  // Reference model: absolute cycle at which each constraint clears.
  bit          m_open, m_ap, m_err;
  logic [13:0] m_row;
  int          dl_rcd, dl_ras, dl_rp, dl_rfc, dl_rtp, dl_wtp;

  function automatic int mx1(input logic [7:0] t);
    return (t == 8'd0) ? 1 : int'(t);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // {act, rd, wr, pre, ref} legality in the current cycle
  function automatic logic [4:0] m_oks();
    bit a, r, p;
    a = !m_open && cyc >= dl_rp && cyc >= dl_rfc;
    r = m_open && !m_ap && cyc >= dl_rcd;
    p = m_open && !m_ap && cyc >= dl_ras && cyc >= dl_rtp && cyc >= dl_wtp;
    return {a, r, r, p, a};
  endfunction

  task automatic model_reset();
    m_open = 0; m_ap = 0; m_err = 0; m_row = 14'd0;
    dl_rcd = 0; dl_ras = 0; dl_rp = 0; dl_rfc = 0; dl_rtp = 0; dl_wtp = 0;
  endtask

  task automatic model_advance();
    logic [4:0] oks;
    int n;
    bit ill;
    if (rst) begin
      model_reset();
    end else begin
      oks = m_oks();
      n = int'(act_i) + int'(rd_i) + int'(wr_i) + int'(pre_i) + int'(ref_i);
      ill = (n > 1) || (act_i && !oks[4]) || (rd_i && !oks[3]) || (wr_i && !oks[2])
            || (pre_i && !oks[1]) || (ref_i && !oks[0]);
`ifdef SAL_BK_AUTO_PRE_EN
      if (m_ap && cyc >= dl_ras && cyc >= dl_rtp && cyc >= dl_wtp) begin
        m_ap = 0; m_open = 0; dl_rp = cyc + mx1(t_rp);
      end
`endif
      if (!ill) begin
        if (act_i) begin
          m_open = 1; m_row = row_i;
          dl_rcd = cyc + mx1(t_rcd); dl_ras = cyc + mx1(t_ras);
        end
        if (rd_i) dl_rtp = imax(dl_rtp, cyc + mx1(t_rtp));
        if (wr_i) dl_wtp = imax(dl_wtp, cyc + mx1(t_wtp));
`ifdef SAL_BK_AUTO_PRE_EN
        if ((rd_i || wr_i) && ap_i) m_ap = 1;
`endif
        if (pre_i) begin m_open = 0; dl_rp = cyc + mx1(t_rp); end
        if (ref_i) dl_rfc = cyc + mx1(t_rfc);
      end
      m_err = ill;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic set_cmd(input int c);
    act_i = (c == 1 || c == 6);
    rd_i  = (c == 2 || c == 7);
    wr_i  = (c == 3 || c == 7);
    pre_i = (c == 4);
    ref_i = (c == 5 || c == 6);
  endtask

  // Compare against the model, advance one clock, clear the strobes.
  task automatic tick();
    @(negedge clk);
    chk("model", {11'd0, act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open, err, open_row},
        {11'd0, m_oks(), m_open, m_err, m_row});
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    set_cmd(0);
    ap_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic set_t(input int rcd, input int ras, input int rtp, input int wtp,
                       input int rp, input int rfc);
    t_rcd = 8'(rcd); t_ras = 8'(ras); t_rtp = 8'(rtp);
    t_wtp = 8'(wtp); t_rp = 8'(rp); t_rfc = 8'(rfc);
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return act_ok;
      1: return rd_ok;
      2: return pre_ok;
      default: return !row_open;
    endcase
  endfunction

  task automatic first_high(input int sel, input int limit, output int rel);
    rel = -1;
    for (int i = 0; i < limit; i++) begin
      if (sig(sel)) begin
        rel = cyc - base;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    int          cmd;
    logic [13:0] row;
    logic [4:0]  exp;      // {act_ok, rd_ok, pre_ok, row_open, err}
    logic [13:0] exp_row;
  } vec_t;

  vec_t tbl[19];

  task automatic setv(input int k, input int c, input logic [4:0] e, input logic [13:0] er);
    tbl[k].cmd = c; tbl[k].row = 14'h0123; tbl[k].exp = e; tbl[k].exp_row = er;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int rel;
    logic [4:0] oks;
    int r, pick, idx;

    rst = 1'b1; set_cmd(0); ap_i = 1'b0; row_i = 14'd0;
    set_t(4, 10, 3, 2, 5, 20);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset_flags", {25'd0, act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open, err},
        {25'd0, 7'b1000100});
    chk("reset_row", {18'd0, open_row}, 32'd0);

    // Directed table: t_rcd=4, t_ras=10, t_rtp=3, t_rp=5, t_rfc=20
    setv(0, 1, 5'b10000, 14'h0000);
    setv(1, 0, 5'b00010, 14'h0123);
    setv(2, 2, 5'b00010, 14'h0123);
    setv(3, 0, 5'b00011, 14'h0123);
    setv(4, 2, 5'b01010, 14'h0123);
    for (int k = 5; k <= 9; k++) setv(k, 0, 5'b01010, 14'h0123);
    setv(10, 0, 5'b01110, 14'h0123);
    setv(11, 4, 5'b01110, 14'h0123);
    for (int k = 12; k <= 15; k++) setv(k, 0, 5'b00000, 14'h0123);
    setv(16, 5, 5'b10000, 14'h0123);
    setv(17, 6, 5'b00000, 14'h0123);
    setv(18, 0, 5'b00001, 14'h0123);
    do_reset();
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("tbl%0d_flags", k), {27'd0, act_ok, rd_ok, pre_ok, row_open, err},
          {27'd0, tbl[k].exp});
      chk($sformatf("tbl%0d_row", k), {18'd0, open_row}, {18'd0, tbl[k].exp_row});
      set_cmd(tbl[k].cmd);
      row_i = tbl[k].row;
      tick();
    end

    // pre_ok bound by rtp: ACT at 0, RD at 8 -> 11
    set_t(2, 10, 3, 1, 1, 1);
    do_reset();
    set_cmd(1); tick();
    repeat (7) tick();
    set_cmd(2); tick();
    first_high(2, 40, rel);
    chk("pre_rtp_bound", rel, 11);

    // pre_ok bound by ras: ACT at 0, RD at 2 -> 10
    do_reset();
    set_cmd(1); tick(); tick();
    set_cmd(2); tick();
    first_high(2, 40, rel);
    chk("pre_ras_bound", rel, 10);

    // longer wtp preserved: WR at 5, RD at 6 -> 14
    set_t(2, 1, 2, 9, 1, 1);
    do_reset();
    set_cmd(1); tick();
    repeat (4) tick();
    set_cmd(3); tick();
    set_cmd(2); tick();
    first_high(2, 40, rel);
    chk("pre_wtp_kept", rel, 14);

    // rp then rfc gating of act_ok
    set_t(1, 1, 1, 1, 5, 20);
    do_reset();
    set_cmd(1); tick();
    first_high(2, 10, rel);
    base = cyc;
    set_cmd(4); tick();
    first_high(0, 40, rel);
    chk("act_after_rp", rel, 5);
    set_cmd(5); tick();
    first_high(0, 60, rel);
    chk("act_after_rfc", rel, 25);

    // illegal commands: one-cycle err, state untouched
    do_reset();
    set_cmd(2); tick();
    chk("rd_closed_err", {30'd0, err, row_open}, {30'd0, 2'b10});
    tick();
    chk("rd_closed_err_drop", {31'd0, err}, 32'd0);
    set_cmd(6); tick();
    chk("act_ref_err", {29'd0, err, row_open, act_ok}, {29'd0, 3'b101});
    tick();
    chk("act_ref_err_drop", {31'd0, err}, 32'd0);

    // t_rcd=0 behaves as 1
    set_t(0, 1, 1, 1, 1, 1);
    do_reset();
    set_cmd(1); tick();
    chk("rcd0_rd_ok", {31'd0, rd_ok}, 32'd1);

    // reset mid-count
    set_t(9, 50, 1, 1, 1, 1);
    do_reset();
    set_cmd(1); row_i = 14'h2aa5; tick();
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_flags", {25'd0, act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open, err},
        {25'd0, 7'b1000100});
    chk("midrst_row", {18'd0, open_row}, 32'd0);

`ifdef SAL_BK_AUTO_PRE_EN
    // auto-precharge: ACT at 0, RD+ap at 2, PRE strobe at 4 -> err, act_ok at 9
    set_t(2, 6, 1, 1, 3, 1);
    do_reset();
    set_cmd(1); tick(); tick();
    set_cmd(2); ap_i = 1'b1; tick();
    chk("ap_pend_flags", {26'd0, act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open},
        {26'd0, 6'b000001});
    tick();
    set_cmd(4); tick();
    chk("ap_pre_err", {31'd0, err}, 32'd1);
    first_high(0, 40, rel);
    chk("ap_act_ok", rel, 9);
    do_reset();
    set_cmd(1); tick(); tick();
    set_cmd(2); ap_i = 1'b1; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ap_rst_flags", {25'd0, act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open, err},
        {25'd0, 7'b1000100});
`endif

    // Random run against the model
    set_t(3, 6, 2, 4, 3, 8);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)
        set_t($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 6),
              $urandom_range(0, 8), $urandom_range(0, 6), $urandom_range(0, 25));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        oks = m_oks();
        if (r >= 40 && r < 85) begin
          pick = $urandom_range(0, 4);
          for (int j = 0; j < 5; j++) begin
            idx = (pick + j) % 5;
            if (oks[4-idx]) begin
              set_cmd(idx + 1);
              break;
            end
          end
        end else if (r >= 85 && r < 95) begin
          set_cmd($urandom_range(1, 5));
        end else if (r >= 95) begin
          set_cmd($urandom_range(6, 7));
        end
        ap_i = 1'($urandom_range(0, 1));
        row_i = 14'($urandom);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
